// File: rtl/rvvi_ack_receiver.sv
// Receive end of the RVVI-over-Ethernet link: parses 9-word host ack frames, tracks sequence, drives ExternalStall.
// Optional destination-MAC filter is compiled in with `define RVVI_ACK_MAC_FILTER_EN.
module rvvi_ack_receiver #(
    parameter logic [15:0] ETH_TYPE        = 16'h005C,
    parameter logic [31:0] MAX_OUTSTANDING = 32'd16,
    parameter logic [47:0] LOCAL_MAC       = 48'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RxData,
    input  logic [3:0]  RxKeep,
    input  logic        RxValid,
    input  logic        RxLast,
    output logic        RxReady,
    input  logic [63:0] SentFrameCount,
    output logic        AckValid,
    output logic [63:0] AckFrameCount,
    output logic [63:0] AckMinstret,
    output logic [31:0] HostLoad,
    output logic [31:0] DroppedFrames,
    output logic [31:0] StaleFrames,
    output logic [31:0] BadFrames,
    output logic        ExternalStall
);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        BODY,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  word_idx;
    logic [31:0] count_lo;
    logic [31:0] count_hi;
    logic [31:0] minstret_lo;
    logic [31:0] minstret_hi;
    logic [63:0] expected_count;

    logic        keep_bad;
    logic        type_bad;
    logic        mac_bad;
    logic        bad_inc;
    logic        commit;
    logic        first_word;
    logic        store_word;

    logic [63:0] rx_count;
    logic        is_stale;
    logic [63:0] gap;
    logic [31:0] gap_clamped;
    logic [32:0] dropped_sum;
    logic [31:0] dropped_next;
    logic [63:0] outstanding;

    assign RxReady  = 1'b1;
    assign keep_bad = (RxKeep != 4'hF);
    assign type_bad = (RxData[15:0] != ETH_TYPE);

`ifdef RVVI_ACK_MAC_FILTER_EN
    logic [31:0] dst_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_lo <= '0;
        end else if (first_word) begin
            dst_lo <= RxData;
        end
    end

    assign mac_bad = ({RxData[15:0], dst_lo} != LOCAL_MAC);
`else
    logic unused_mac;

    assign unused_mac = ^LOCAL_MAC;
    assign mac_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC: begin
                if (!RxValid || RxLast) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (RxValid) begin
                    if (RxLast) begin
                        state_next = IDLE;
                    end else if (keep_bad) begin
                        state_next = DROP;
                    end else begin
                        state_next = HDR;
                    end
                end
            end
            HDR: begin
                if (RxValid) begin
                    if (RxLast) begin
                        state_next = IDLE;
                    end else if (keep_bad) begin
                        state_next = DROP;
                    end else if (word_idx == 4'd1 && mac_bad) begin
                        state_next = DROP;
                    end else if (word_idx == 4'd3) begin
                        state_next = type_bad ? DROP : BODY;
                    end
                end
            end
            BODY: begin
                if (RxValid) begin
                    // Keep is not checked on w8: the MAC may trim padding on the final word.
                    if (word_idx == 4'd8) begin
                        state_next = RxLast ? IDLE : DROP;
                    end else if (RxLast) begin
                        state_next = IDLE;
                    end else if (keep_bad) begin
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (RxValid && RxLast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_comb begin
        bad_inc    = 1'b0;
        commit     = 1'b0;
        first_word = 1'b0;
        store_word = 1'b0;
        case (state)
            IDLE: begin
                if (RxValid) begin
                    if (RxLast || keep_bad) begin
                        bad_inc = 1'b1;
                    end else begin
                        first_word = 1'b1;
                    end
                end
            end
            HDR: begin
                if (RxValid && (RxLast || keep_bad)) begin
                    bad_inc = 1'b1;
                end
            end
            BODY: begin
                if (RxValid) begin
                    if (word_idx == 4'd8) begin
                        if (RxLast) begin
                            commit = 1'b1;
                        end else begin
                            bad_inc = 1'b1;
                        end
                    end else if (RxLast || keep_bad) begin
                        bad_inc = 1'b1;
                    end else begin
                        store_word = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= '0;
        end else if (first_word) begin
            word_idx <= 4'd1;
        end else if (RxValid && (state == HDR || state == BODY)) begin
            word_idx <= word_idx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_lo    <= '0;
            count_hi    <= '0;
            minstret_lo <= '0;
            minstret_hi <= '0;
        end else if (store_word) begin
            case (word_idx)
                4'd4:    count_lo    <= RxData;
                4'd5:    count_hi    <= RxData;
                4'd6:    minstret_lo <= RxData;
                4'd7:    minstret_hi <= RxData;
                default: ;
            endcase
        end
    end

    // The sequence gap is clamped to 32 bits before the add so a huge jump still saturates cleanly.
    assign rx_count     = {count_hi, count_lo};
    assign is_stale     = (rx_count < expected_count);
    assign gap          = rx_count - expected_count;
    assign gap_clamped  = (|gap[63:32]) ? 32'hFFFF_FFFF : gap[31:0];
    assign dropped_sum  = {1'b0, DroppedFrames} + {1'b0, gap_clamped};
    assign dropped_next = dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
    assign outstanding  = SentFrameCount - expected_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            AckValid       <= 1'b0;
            AckFrameCount  <= '0;
            AckMinstret    <= '0;
            HostLoad       <= '0;
            DroppedFrames  <= '0;
            StaleFrames    <= '0;
            expected_count <= '0;
        end else begin
            AckValid <= 1'b0;
            if (commit) begin
                if (is_stale) begin
                    if (StaleFrames != 32'hFFFF_FFFF) begin
                        StaleFrames <= StaleFrames + 32'd1;
                    end
                end else begin
                    AckValid       <= 1'b1;
                    AckFrameCount  <= rx_count;
                    AckMinstret    <= {minstret_hi, minstret_lo};
                    HostLoad       <= RxData;
                    DroppedFrames  <= dropped_next;
                    expected_count <= rx_count + 64'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            BadFrames <= '0;
        end else if (bad_inc && BadFrames != 32'hFFFF_FFFF) begin
            BadFrames <= BadFrames + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ExternalStall <= 1'b0;
        end else begin
            ExternalStall <= (outstanding >= {32'd0, MAX_OUTSTANDING});
        end
    end

endmodule

// File: tb/tb_rvvi_ack_receiver.sv
// Directed self-checking bench for rvvi_ack_receiver: sequencing, malformed frames, stall and reset recovery.
module tb_rvvi_ack_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RxData;
    logic [3:0]  RxKeep;
    logic        RxValid;
    logic        RxLast;
    logic        RxReady;
    logic [63:0] SentFrameCount;
    logic        AckValid;
    logic [63:0] AckFrameCount;
    logic [63:0] AckMinstret;
    logic [31:0] HostLoad;
    logic [31:0] DroppedFrames;
    logic [31:0] StaleFrames;
    logic [31:0] BadFrames;
    logic        ExternalStall;

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_pulses   = 0;

    rvvi_ack_receiver dut (
        .clk(clk),
        .reset(reset),
        .RxData(RxData),
        .RxKeep(RxKeep),
        .RxValid(RxValid),
        .RxLast(RxLast),
        .RxReady(RxReady),
        .SentFrameCount(SentFrameCount),
        .AckValid(AckValid),
        .AckFrameCount(AckFrameCount),
        .AckMinstret(AckMinstret),
        .HostLoad(HostLoad),
        .DroppedFrames(DroppedFrames),
        .StaleFrames(StaleFrames),
        .BadFrames(BadFrames),
        .ExternalStall(ExternalStall)
    );

    always #5 clk = ~clk;

    // Every cycle AckValid is high adds one, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (AckValid === 1'b1) begin
            ack_pulses++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] frame_word(input int idx, input logic [63:0] cnt,
                                               input logic [63:0] mins, input logic [31:0] load,
                                               input logic [15:0] etype, input logic [47:0] dst);
        case (idx)
            0:       return dst[31:0];
            1:       return {16'hBEEF, dst[47:32]};
            2:       return 32'hCAFE_0001;
            3:       return {16'h0000, etype};
            4:       return cnt[31:0];
            5:       return cnt[63:32];
            6:       return mins[31:0];
            7:       return mins[63:32];
            default: return load;
        endcase
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        @(posedge clk);
        #1;
        RxData  = d;
        RxKeep  = k;
        RxValid = 1'b1;
        RxLast  = l;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        RxValid = 1'b0;
        RxLast  = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] cnt, input logic [63:0] mins, input logic [31:0] load,
                              input logic [15:0] etype, input logic [47:0] dst, input logic [3:0] keep8);
        for (int i = 0; i < 9; i++) begin
            drive_beat(frame_word(i, cnt, mins, load, etype, dst), (i == 8) ? keep8 : 4'hF, i == 8);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        RxValid        = 1'b0;
        RxLast         = 1'b0;
        RxKeep         = 4'hF;
        RxData         = '0;
        SentFrameCount = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (RxReady !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %0b expected 1", RxReady);
        end
        tests_run++;
        if (AckValid !== 1'b0 || ExternalStall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got valid=%0b stall=%0b expected 0/0", AckValid, ExternalStall);
        end
        tests_run++;
        if (AckFrameCount !== 64'd0 || AckMinstret !== 64'd0 || HostLoad !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ack_regs: got %h %h %h expected zeros", AckFrameCount, AckMinstret, HostLoad);
        end
        tests_run++;
        if (DroppedFrames !== 32'd0 || StaleFrames !== 32'd0 || BadFrames !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_counters: got d=%0d s=%0d b=%0d expected 0/0/0",
                     DroppedFrames, StaleFrames, BadFrames);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame(64'd0, 64'h1234, 32'h1, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (AckValid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL good_ack_valid: got %0b expected 1", AckValid);
        end
        tests_run++;
        if (AckFrameCount !== 64'd0 || AckMinstret !== 64'h1234 || HostLoad !== 32'h1) begin
            tests_failed++;
            $display("[TB] FAIL good_ack_data: got cnt=%h mins=%h load=%h expected 0/1234/1",
                     AckFrameCount, AckMinstret, HostLoad);
        end
        drive_idle();
        tests_run++;
        if (AckValid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL good_ack_pulse_width: got %0b expected 0", AckValid);
        end
        // ExpectedCount is now 1, so a repeat of count 0 must be stale.
        send_frame(64'd0, 64'h1, 32'h2, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (StaleFrames !== 32'd1 || AckValid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL good_expected_advanced: got stale=%0d valid=%0b expected 1/0", StaleFrames, AckValid);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = ack_pulses;
        send_frame(64'd0, 64'h10, 32'hA0, 16'h005C, 48'h0, 4'hF);
        send_frame(64'd1, 64'h11, 32'hA1, 16'h005C, 48'h0, 4'hF);
        send_frame(64'd5, 64'h15, 32'hA5, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        drive_idle();
        tests_run++;
        if (ack_pulses - base !== 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_pulses: got %0d expected 3", ack_pulses - base);
        end
        tests_run++;
        if (DroppedFrames !== 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_dropped: got %0d expected 3", DroppedFrames);
        end
        tests_run++;
        if (AckFrameCount !== 64'd5 || AckMinstret !== 64'h15 || HostLoad !== 32'hA5) begin
            tests_failed++;
            $display("[TB] FAIL b2b_last_ack: got cnt=%h mins=%h load=%h expected 5/15/a5",
                     AckFrameCount, AckMinstret, HostLoad);
        end
    endtask

    task automatic test_stale();
        int base;
        base = ack_pulses;
        send_frame(64'd2, 64'h22, 32'hB2, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        drive_idle();
        tests_run++;
        if (StaleFrames !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL stale_count: got %0d expected 1", StaleFrames);
        end
        tests_run++;
        if (AckFrameCount !== 64'd5 || HostLoad !== 32'hA5 || DroppedFrames !== 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL stale_no_update: got cnt=%h load=%h dropped=%0d expected 5/a5/3",
                     AckFrameCount, HostLoad, DroppedFrames);
        end
        tests_run++;
        if (ack_pulses - base !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stale_no_pulse: got %0d pulses expected 0", ack_pulses - base);
        end
    endtask

    task automatic test_malformed();
        int base;
        do_reset();
        base = ack_pulses;
        for (int i = 0; i < 6; i++) begin
            drive_beat(frame_word(i, 64'd1, 64'h0, 32'h0, 16'h005C, 48'h0), 4'hF, i == 5);
        end
        for (int i = 0; i < 9; i++) begin
            drive_beat(frame_word(i, 64'd2, 64'h0, 32'h0, 16'h005C, 48'h0), 4'hF, 1'b0);
        end
        drive_beat(32'h0, 4'hF, 1'b1);
        drive_beat(32'h0, 4'hF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive_beat(frame_word(i, 64'd4, 64'h0, 32'h0, 16'h005C, 48'h0), (i == 2) ? 4'h7 : 4'hF, i == 8);
        end
        send_frame(64'd7, 64'h0, 32'h0, 16'h0800, 48'h0, 4'hF);
        drive_idle();
        drive_idle();
        tests_run++;
        if (BadFrames !== 32'd4) begin
            tests_failed++;
            $display("[TB] FAIL malformed_bad_count: got %0d expected 4", BadFrames);
        end
        tests_run++;
        if (ack_pulses - base !== 0 || DroppedFrames !== 32'd0 || StaleFrames !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL malformed_ignored: got pulses=%0d dropped=%0d stale=%0d expected 0/0/0",
                     ack_pulses - base, DroppedFrames, StaleFrames);
        end
        send_frame(64'd3, 64'h55, 32'h9, 16'h005C, 48'h0, 4'h0);
        drive_idle();
        tests_run++;
        if (AckValid !== 1'b1 || AckFrameCount !== 64'd3 || HostLoad !== 32'h9) begin
            tests_failed++;
            $display("[TB] FAIL malformed_recovery: got valid=%0b cnt=%h load=%h expected 1/3/9",
                     AckValid, AckFrameCount, HostLoad);
        end
        tests_run++;
        if (DroppedFrames !== 32'd3 || BadFrames !== 32'd4) begin
            tests_failed++;
            $display("[TB] FAIL malformed_recovery_counters: got dropped=%0d bad=%0d expected 3/4",
                     DroppedFrames, BadFrames);
        end
    endtask

    task automatic test_stall();
        do_reset();
        SentFrameCount = 64'd15;
        drive_idle();
        drive_idle();
        tests_run++;
        if (ExternalStall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_below_limit: got %0b expected 0", ExternalStall);
        end
        SentFrameCount = 64'd16;
        drive_idle();
        tests_run++;
        if (ExternalStall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_at_limit: got %0b expected 1", ExternalStall);
        end
        send_frame(64'd0, 64'h0, 32'h0, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (ExternalStall !== 1'b1 || AckValid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_commit_edge: got stall=%0b valid=%0b expected 1/1", ExternalStall, AckValid);
        end
        drive_idle();
        tests_run++;
        if (ExternalStall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_release: got %0b expected 0", ExternalStall);
        end
    endtask

    task automatic test_saturation_wrap();
        int base;
        do_reset();
        base = ack_pulses;
        send_frame(64'h1_0000_0005, 64'h0, 32'h0, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (DroppedFrames !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL sat_dropped: got %h expected ffffffff", DroppedFrames);
        end
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 32'h0, 16'h005C, 48'h0, 4'hF);
        send_frame(64'd0, 64'h0, 32'h3C, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (AckFrameCount !== 64'd0 || HostLoad !== 32'h3C || StaleFrames !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_accept: got cnt=%h load=%h stale=%0d expected 0/3c/0",
                     AckFrameCount, HostLoad, StaleFrames);
        end
        drive_idle();
        tests_run++;
        if (ack_pulses - base !== 3 || DroppedFrames !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pulses: got pulses=%0d dropped=%h expected 3/ffffffff",
                     ack_pulses - base, DroppedFrames);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_beat(frame_word(i, 64'd9, 64'h0, 32'h0, 16'h005C, 48'h0), 4'hF, 1'b0);
        end
        drive_beat(frame_word(3, 64'd9, 64'h0, 32'h0, 16'h005C, 48'h0), 4'hF, 1'b0);
        reset = 1'b1;
        drive_beat(32'd9, 4'hF, 1'b0);
        reset = 1'b0;
        drive_beat(32'd0, 4'hF, 1'b0);
        drive_beat(32'h0, 4'hF, 1'b0);
        drive_beat(32'h0, 4'hF, 1'b1);
        base = ack_pulses;
        send_frame(64'd0, 64'hABCD, 32'h77, 16'h005C, 48'h0, 4'hF);
        drive_idle();
        tests_run++;
        if (AckValid !== 1'b1 || AckMinstret !== 64'hABCD || HostLoad !== 32'h77) begin
            tests_failed++;
            $display("[TB] FAIL midreset_commit: got valid=%0b mins=%h load=%h expected 1/abcd/77",
                     AckValid, AckMinstret, HostLoad);
        end
        tests_run++;
        if (BadFrames !== 32'd0 || StaleFrames !== 32'd0 || DroppedFrames !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_counters: got b=%0d s=%0d d=%0d expected 0/0/0",
                     BadFrames, StaleFrames, DroppedFrames);
        end
`ifdef RVVI_ACK_MAC_FILTER_EN
        send_frame(64'd1, 64'h1, 32'h1, 16'h005C, 48'h0000_0000_0001, 4'hF);
        drive_idle();
        drive_idle();
        tests_run++;
        if (ack_pulses - base !== 1 || BadFrames !== 32'd0 || AckFrameCount !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL mac_filter_drop: got pulses=%0d bad=%0d cnt=%h expected 1/0/0",
                     ack_pulses - base, BadFrames, AckFrameCount);
        end
`else
        drive_idle();
        tests_run++;
        if (ack_pulses - base !== 1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pulses: got %0d expected 1", ack_pulses - base);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_stale();
        test_malformed();
        test_stall();
        test_saturation_wrap();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
